fc_feeder: RTL and testbench
============================

Name: fc_feeder

Overview:
- Producer-side front end of the fully-connected classifier stage.
- Collects the 64 flattened int8 features from the preceding pooling stage, one byte per handshake, into a local buffer.
- Streams the features to the FC layer as 16 beats of 4 lanes with the enable held high, then waits for the FC done flag and captures the class.
- Drops the enable to clear the FC layer and reports the result downstream.

Parameters:
- N_FEAT, 64, features per frame; must equal LANES*N_BEATS.
- LANES, 4, bytes per FC beat.
- DW, 8, feature width in bits (signed).
- WAIT_MAX, 4, cycles to wait for fc_flag after the last beat before declaring an error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  upstream feature byte valid
- s_data  in  DW  upstream feature byte, signed
- s_ready  out  1  feeder accepts s_data this cycle
- fc_en  out  1  enable to FC layer
- fc_in  out  LANES x DW packed signed  lane k = feature 4*beat+k
- fc_flag  in  1  FC done flag
- fc_class  in  2  FC class output, valid while fc_flag=1
- res_valid  out  1  one-cycle result strobe
- res_class  out  2  captured class; held until the next res_valid
- res_err  out  1  qualifies res_valid: FC timeout
- busy  out  1  high in any state other than FILL with an empty buffer

Behaviour:
- Reset (synchronous, active-high) sets:
  - state=FILL; write pointer 0; beat counter 0; wait counter 0
  - fc_en=0, fc_in=0, s_ready=0 during reset
  - res_valid=0, res_class=0, res_err=0, busy=0
- A mid-frame reset discards buffered bytes. Because fc_en=0 while reset is asserted, the FC layer is cleared.
- FILL:
  - s_ready=1. A byte is accepted when s_valid&&s_ready, stored at buf[wr_ptr], and wr_ptr increments.
  - On acceptance of byte 63, wr_ptr wraps to 0 and the next state is STREAM.
  - No lookahead: s_ready depends only on state.
- STREAM, beat b = 0..15:
  - fc_en=1, fc_in lane k = buf[4b+k], one beat per cycle, no stalls.
  - After b=15 the next state is WAIT. s_ready=0.
- WAIT:
  - fc_en=1 (the FC holds its accumulators), fc_in=0.
  - If fc_flag=1, capture fc_class into res_class, res_err=0, and go to DONE.
  - Otherwise increment the wait counter. When it reaches WAIT_MAX-1 without fc_flag, set res_class=0, res_err=1, and go to DONE.
  - With a compliant FC, fc_flag is seen in the first WAIT cycle. Latency from last-beat edge to res_valid is 2 cycles.
- DONE:
  - fc_en=0 for exactly one cycle; this clears the FC layer.
  - res_valid=1 for this cycle only; then go to FILL.
- Frame spacing: the minimum gap between frames is one cycle with fc_en=0. fc_en is never high across a frame boundary.
- Boundary rules:
  - s_valid during STREAM/WAIT/DONE is not accepted (s_ready=0); upstream holds.
  - fc_flag asserted during STREAM is ignored.
  - res_err is meaningful only when res_valid=1.
- Outputs fc_en, fc_in, s_ready, res_valid and busy are registered or decoded directly from the state and buffer registers. There is no combinational path from fc_flag to fc_en within the same cycle.

Optional Feature:
- Macro: FC_FEEDER_PINGPONG_EN.
- Defined:
  - Two 64-byte banks. The write bank fills while the other bank streams.
  - s_ready=1 whenever the write bank is not full, regardless of state.
  - From DONE: go to STREAM on the other bank if it is full, else to FILL. In FILL, the state becomes STREAM the cycle after the write bank is filled and the read bank is free; banks then swap.
  - busy=1 whenever either bank holds data.
- Undefined: single bank, behaviour exactly as above. A second frame is not accepted until DONE completes.

Decomposition:
- Package fc_pkg:
  - FC_LANES=4, FC_DW=8, FC_NFEAT=64, FC_NBEATS=16
  - typedef logic signed [FC_LANES-1:0][FC_DW-1:0] fc_beat_t
  - typedef enum {FILL, STREAM, WAIT, DONE} fc_feed_state_e
  - class code constants CLS_NORMAL=0, CLS_ABNORMAL=1
- One sub-module, fc_feat_buf: a byte-write, 4-byte-read register buffer with a bank select when the macro is on.
- FSM and counters live in fc_feeder.

Test Plan:
- Push bytes 0..63 back-to-back, FC model flags one cycle after beat 15 with class 1 -> exactly 16 fc_en beats with fc_in beat 0 = {3,2,1,0} and beat 15 = {63,62,61,60}; res_valid one cycle later with res_class=1, res_err=0; fc_en low for one cycle.
- s_valid toggled 50% randomly -> all 64 bytes stored in order, STREAM begins only after byte 63, no fc_en before that.
- FC model never asserts fc_flag -> res_valid with res_err=1, res_class=0 after WAIT_MAX=4 WAIT cycles; next frame still processed correctly.
- rst asserted at byte 30 and again at beat 7 -> fc_en=0 and state FILL the next cycle; a new 64-byte frame then produces the correct result.
- fc_flag pulsed during STREAM beat 5 -> ignored; the result comes from the flag in WAIT.
- With FC_FEEDER_PINGPONG_EN, two frames pushed back-to-back -> s_ready stays high through the first frame's STREAM, second STREAM begins the cycle after the first DONE, and results arrive in order.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and constants for the FC classifier feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fc_pkg;

  localparam int FC_LANES  = 4;
  localparam int FC_DW     = 8;
  localparam int FC_NFEAT  = 64;
  localparam int FC_NBEATS = 16;

  typedef logic signed [FC_LANES-1:0][FC_DW-1:0] fc_beat_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } fc_feed_state_e;

  localparam logic [1:0] CLS_NORMAL   = 2'd0;
  localparam logic [1:0] CLS_ABNORMAL = 2'd1;

endpackage

// File: rtl/fc_feat_buf.sv
// Feature buffer: byte-wide writes, LANES-byte-wide reads (one FC beat).
// Latency: write visible the cycle after we_i; read is combinational from beat index.
// Backpressure: none, always accepts writes; the owner sequences access.
// Ports: clk_i; we_i/waddr_i/wdata_i write port; rbeat_i read beat index;
//        rdata_o LANES packed bytes (lane k = byte LANES*beat+k).
// With FC_FEEDER_PINGPONG_EN defined, two banks selected by wbank_i / rbank_i.
module fc_feat_buf
  import fc_pkg::*;
#(
  parameter int N_FEAT = FC_NFEAT,
  parameter int LANES  = FC_LANES,
  parameter int DW     = FC_DW
) (
  input  logic                                clk_i,
  input  logic                                we_i,
  input  logic [$clog2(N_FEAT)-1:0]           waddr_i,
  input  logic [DW-1:0]                       wdata_i,
`ifdef FC_FEEDER_PINGPONG_EN
  input  logic                                wbank_i,
  input  logic                                rbank_i,
`endif
  input  logic [$clog2(N_FEAT/LANES)-1:0]     rbeat_i,
  output logic signed [LANES-1:0][DW-1:0]     rdata_o
);

  localparam int LW = $clog2(LANES);
`ifdef FC_FEEDER_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int TW = $clog2(NBANK*N_FEAT);

  logic [DW-1:0]    mem_q [NBANK*N_FEAT];
  logic [TW-1:0]    waddr;
  logic [TW-LW-1:0] rrow;

`ifdef FC_FEEDER_PINGPONG_EN
  assign waddr = {wbank_i, waddr_i};
  assign rrow  = {rbank_i, rbeat_i};
`else
  assign waddr = waddr_i;
  assign rrow  = rbeat_i;
`endif

  // Storage needs no reset: the owner's write pointer decides what is valid.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr] <= wdata_i;
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      rdata_o[k] = mem_q[{rrow, LW'(k)}];
    end
  end

endmodule

// File: rtl/fc_feeder.sv
// Feeder for the FC classifier: gathers N_FEAT bytes, streams N_FEAT/LANES beats, collects class.
// Latency: first beat the cycle after byte N_FEAT-1 is accepted; res_valid 2 cycles after last beat.
// Backpressure: s_ready only in FILL (ping-pong build: while write bank not full); no FC stalls.
// Ports: clk, rst (sync, active-high); s_valid/s_data/s_ready upstream byte stream;
//        fc_en/fc_in to FC layer, fc_flag/fc_class from it; res_valid/res_class/res_err result;
//        busy = frame activity. Optional build macro: FC_FEEDER_PINGPONG_EN (two buffer banks).
module fc_feeder
  import fc_pkg::*;
#(
  parameter int N_FEAT   = FC_NFEAT,
  parameter int LANES    = FC_LANES,
  parameter int DW       = FC_DW,
  parameter int WAIT_MAX = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  input  logic signed [DW-1:0]            s_data,
  output logic                            s_ready,
  output logic                            fc_en,
  output logic signed [LANES-1:0][DW-1:0] fc_in,
  input  logic                            fc_flag,
  input  logic [1:0]                      fc_class,
  output logic                            res_valid,
  output logic [1:0]                      res_class,
  output logic                            res_err,
  output logic                            busy
);

  localparam int N_BEATS = N_FEAT / LANES;
  localparam int PW      = $clog2(N_FEAT);
  localparam int BW      = $clog2(N_BEATS);
  localparam int WW      = $clog2(WAIT_MAX + 1);

  fc_feed_state_e state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [1:0]     res_class_q, res_class_d;
  logic           res_err_q, res_err_d;
  logic           acc, last_byte;
  logic signed [LANES-1:0][DW-1:0] rd_beat;
`ifdef FC_FEEDER_PINGPONG_EN
  logic           wbank_q, wbank_d, rbank_q, rbank_d;
  logic [1:0]     full_q, full_d;
`endif

  // Upstream handshake and output decode; rst gates everything to idle immediately.
`ifdef FC_FEEDER_PINGPONG_EN
  assign s_ready = !rst && !full_q[wbank_q];
  assign busy    = !rst && ((|full_q) || (wr_ptr_q != '0) || (state_q != FILL));
`else
  assign s_ready = !rst && (state_q == FILL);
  assign busy    = !rst && !((state_q == FILL) && (wr_ptr_q == '0));
`endif
  assign acc       = s_valid && s_ready;
  assign last_byte = acc && (wr_ptr_q == PW'(N_FEAT - 1));
  assign fc_en     = !rst && ((state_q == STREAM) || (state_q == WAIT));
  assign fc_in     = (!rst && (state_q == STREAM)) ? rd_beat : '0;
  assign res_valid = !rst && (state_q == DONE);
  assign res_class = res_class_q;
  assign res_err   = res_err_q;

  fc_feat_buf #(.N_FEAT(N_FEAT), .LANES(LANES), .DW(DW)) u_buf (
    .clk_i   (clk),
    .we_i    (acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_data),
`ifdef FC_FEEDER_PINGPONG_EN
    .wbank_i (wbank_q),
    .rbank_i (rbank_q),
`endif
    .rbeat_i (beat_q),
    .rdata_o (rd_beat)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    res_class_d = res_class_q;
    res_err_d   = res_err_q;
`ifdef FC_FEEDER_PINGPONG_EN
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    full_d      = full_q;
    if (last_byte) full_d[wbank_q] = 1'b1;
`endif
    // Pointer width is exactly log2(N_FEAT), so byte N_FEAT-1 wraps to 0.
    if (acc) wr_ptr_d = wr_ptr_q + 1'b1;

    case (state_q)
      FILL: begin
`ifdef FC_FEEDER_PINGPONG_EN
        // Read bank is free in FILL; start streaming once the write bank is full.
        if (full_q[wbank_q]) begin
          state_d = STREAM;
          beat_d  = '0;
          rbank_d = wbank_q;
          wbank_d = !wbank_q;
        end
`else
        if (last_byte) begin
          state_d = STREAM;
          beat_d  = '0;
        end
`endif
      end
      STREAM: begin
        // fc_flag deliberately ignored while beats are still going out.
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(N_BEATS - 1)) begin
          state_d = WAIT;
          beat_d  = '0;
          wait_d  = '0;
        end
      end
      WAIT: begin
        if (fc_flag) begin
          res_class_d = fc_class;
          res_err_d   = 1'b0;
          state_d     = DONE;
        end else if (wait_q == WW'(WAIT_MAX - 1)) begin
          res_class_d = CLS_NORMAL;
          res_err_d   = 1'b1;
          state_d     = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE: begin
        state_d = FILL;
`ifdef FC_FEEDER_PINGPONG_EN
        full_d[rbank_q] = 1'b0;
        if (full_q[wbank_q]) begin
          state_d = STREAM;
          beat_d  = '0;
          rbank_d = wbank_q;
          wbank_d = !wbank_q;
        end
`endif
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      res_class_q <= '0;
      res_err_q   <= 1'b0;
`ifdef FC_FEEDER_PINGPONG_EN
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b1;
      full_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      res_class_q <= res_class_d;
      res_err_q   <= res_err_d;
`ifdef FC_FEEDER_PINGPONG_EN
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      full_q      <= full_d;
`endif
    end
  end

endmodule

// File: tb/tb_fc_feeder.sv
// Bench for fc_feeder (single-bank build): frame scenarios from a table plus reset corner cases.
module tb_fc_feeder;

  logic                  clk;
  logic                  rst;
  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic                  fc_en;
  logic signed [3:0][7:0] fc_in;
  logic                  fc_flag;
  logic [1:0]            fc_class;
  logic                  res_valid;
  logic [1:0]            res_class;
  logic                  res_err;
  logic                  busy;

  fc_feeder #(.N_FEAT(64), .LANES(4), .DW(8), .WAIT_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .fc_en     (fc_en),
    .fc_in     (fc_in),
    .fc_flag   (fc_flag),
    .fc_class  (fc_class),
    .res_valid (res_valid),
    .res_class (res_class),
    .res_err   (res_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit         rnd_data;
    bit         rnd_valid;
    bit         never_flag;
    bit         stray;
    logic [1:0] cls;
    int         abort_byte;
    int         abort_beat;
    logic [1:0] exp_cls;
    bit         exp_err;
    int         nwait;
  } frame_t;

  // Expected cycles from the last accepted byte:
  //   t=0..15 beats (lane k = byte 4t+k), then nwait cycles with fc_en=1 and fc_in=0,
  //   then one result cycle with fc_en=0, then idle FILL with an empty buffer.
  task automatic run_frame(input frame_t f);
    logic [7:0]  bytes [64];
    logic [31:0] exp_in;
    bit          exp_en, exp_rv;
    int          i, guard, early, en_seen, last;
    for (int k = 0; k < 64; k++) bytes[k] = f.rnd_data ? 8'($urandom) : 8'(k);
    i = 0; guard = 0; early = 0;
    while (i < 64 && guard < 1000) begin
      @(negedge clk);
      if (fc_en) early++;
      if (i == f.abort_byte) begin
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        chk("rst_byte_s_ready", 32'(s_ready), 32'd0);
        chk("rst_byte_fc_en", 32'(fc_en), 32'd0);
        chk("rst_byte_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_byte_busy", 32'(busy), 32'd0);
        chk("post_rst_byte_s_ready", 32'(s_ready), 32'd1);
        return;
      end
      s_valid = f.rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = bytes[i];
      if (s_valid && s_ready) i++;
      guard++;
    end
    chk("bytes_accepted", 32'(i), 32'd64);
    chk("fc_en_during_fill", 32'(early), 32'd0);

    en_seen = 0;
    last    = 16 + f.nwait + 1;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      s_valid = (t < 16 + f.nwait) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_data  = 8'($urandom);
      exp_in  = '0;
      if (t < 16) begin
        exp_en = 1'b1; exp_rv = 1'b0;
        exp_in = {bytes[4*t+3], bytes[4*t+2], bytes[4*t+1], bytes[4*t]};
      end else if (t < 16 + f.nwait) begin
        exp_en = 1'b1; exp_rv = 1'b0;
      end else if (t == 16 + f.nwait) begin
        exp_en = 1'b0; exp_rv = 1'b1;
      end else begin
        exp_en = 1'b0; exp_rv = 1'b0;
      end
      chk($sformatf("fc_en_t%0d", t), 32'(fc_en), 32'(exp_en));
      chk($sformatf("fc_in_t%0d", t), 32'(fc_in), exp_in);
      chk($sformatf("res_valid_t%0d", t), 32'(res_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("res_class", 32'(res_class), 32'(f.exp_cls));
        chk("res_err", 32'(res_err), 32'(f.exp_err));
      end
      if (t < last) chk($sformatf("s_ready_t%0d", t), 32'(s_ready), 32'd0);
      else begin
        chk("idle_s_ready", 32'(s_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
      end
      if (t == f.abort_beat) begin
        fc_flag = 1'b0;
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        chk("rst_beat_fc_en", 32'(fc_en), 32'd0);
        chk("rst_beat_fc_in", 32'(fc_in), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_beat_fc_en", 32'(fc_en), 32'd0);
        chk("post_rst_beat_busy", 32'(busy), 32'd0);
        chk("post_rst_beat_s_ready", 32'(s_ready), 32'd1);
        return;
      end
      // FC model: raises its done flag on the first enabled cycle after 16 beats.
      if (fc_en) en_seen++;
      fc_flag  = 1'b0;
      fc_class = 2'($urandom);
      if (!f.never_flag && fc_en && en_seen > 16) begin
        fc_flag  = 1'b1;
        fc_class = f.cls;
      end
      if (f.stray && t == 5) begin
        fc_flag  = 1'b1;
        fc_class = ~f.cls;
      end
    end
    fc_flag = 1'b0;
  endtask

  frame_t tbl [6];
  frame_t hs;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rndD rndV never stray cls  abB abT  expC  err nwait
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, -1, -1, 2'd1, 1'b0, 1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, -1, -1, 2'd2, 1'b0, 1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, -1, -1, 2'd0, 1'b1, 4};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, -1, -1, 2'd3, 1'b0, 1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, -1, -1, 2'd1, 1'b0, 1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, -1, -1, 2'd0, 1'b0, 1};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; fc_flag = 1'b0; fc_class = '0;
    repeat (3) @(negedge clk);
    chk("reset_s_ready", 32'(s_ready), 32'd0);
    chk("reset_fc_en", 32'(fc_en), 32'd0);
    chk("reset_fc_in", 32'(fc_in), 32'd0);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_s_ready", 32'(s_ready), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_res_class", 32'(res_class), 32'd0);
    chk("init_res_err", 32'(res_err), 32'd0);

    for (int r = 0; r < 6; r++) run_frame(tbl[r]);

    // Reset in the middle of filling, then a clean frame.
    hs = tbl[0]; hs.abort_byte = 30; hs.rnd_data = 1'b1;
    run_frame(hs);
    run_frame(tbl[0]);

    // Reset during beat 7, then a clean frame.
    hs = tbl[1]; hs.abort_beat = 7;
    run_frame(hs);
    run_frame(tbl[3]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
